// File: rtl/dcache_direct_mapped_if.sv
// rtl/dcache_direct_mapped_if.sv - processor and block-memory signal bundle for dcache_direct_mapped
// The slave modport is the cache side; the master modport is the pipeline plus main memory.
interface dcache_direct_mapped_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate cache with 4-word blocks
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_direct_mapped #(
  parameter int INDEX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_direct_mapped_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ptag;
  logic [6:0]         word_lsb;
  logic [TAG_W-1:0]   cur_tag;
  logic [127:0]       cur_data;
  logic               req;
  logic               hit;
  logic               stall_c;
  logic               line_we;
  logic [127:0]       line_data_d;
  logic [TAG_W-1:0]   line_tag_d;

  assign idx      = bus.proc_addr[INDEX_W+1:2];
  assign ptag     = bus.proc_addr[29:INDEX_W+2];
  assign word_lsb = {bus.proc_addr[1:0], 5'b00000};
  assign cur_tag  = tag_q[idx];
  assign cur_data = data_q[idx];
  assign req      = bus.proc_read | bus.proc_write;
  assign hit      = valid_q[idx] & (cur_tag == ptag) & req;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    stall_c     = 1'b0;
    line_we     = 1'b0;
    line_data_d = cur_data;
    line_tag_d  = cur_tag;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          // A simultaneous read and write is treated as a write.
          if (bus.proc_write) begin
            line_we                     = 1'b1;
            line_data_d[word_lsb +: 32] = bus.proc_wdata;
            dirty_d[idx]                = 1'b1;
          end
        end else if (req) begin
          stall_c = 1'b1;
          state_d = (valid_q[idx] & dirty_q[idx]) ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        stall_c = 1'b1;
        if (bus.mem_ready) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          line_we      = 1'b1;
          line_data_d  = bus.mem_rdata;
          line_tag_d   = ptag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) line_we = 1'b0;
    mem_read_d  = (state_d == S_ALLOC);
    mem_write_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_data_d;
      tag_q[idx]  <= line_tag_d;
    end
  end

  assign bus.proc_rdata = rst ? 32'd0 : cur_data[word_lsb +: 32];
  assign bus.proc_stall = stall_c & ~rst;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = (state_q == S_WB) ? {cur_tag, idx} : {ptag, idx};
  assign bus.mem_wdata  = cur_data;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && hit && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == S_IDLE && req && !hit && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule
